// File: rtl/psk_pkg.sv
// Shared PSK definitions: mode encodings, default amplitudes and the symbol
// mapper, also used by the Rx reference model.
package psk_pkg;

   localparam logic [3:0] MODE_BPSK = 4'b0001;
   localparam logic [3:0] MODE_QPSK = 4'b0010;
   localparam logic [3:0] MODE_MIX  = 4'b0100;

   localparam int DEF_AMP_BPSK  = 2047;
   localparam int DEF_AMP_QPSK  = 1447;
   localparam int DEF_HDR_BYTES = 2;

   typedef enum logic [1:0] {
      FM_BPSK,
      FM_QPSK,
      FM_MIX
   } frame_mode_t;

   typedef struct packed {
      logic signed [31:0] i;
      logic signed [31:0] q;
   } iq_t;

   // Anything that is not exactly QPSK or MIX falls back to BPSK.
   function automatic frame_mode_t decode_mode(input logic [3:0] m);
      case (m)
         MODE_QPSK: return FM_QPSK;
         MODE_MIX:  return FM_MIX;
         default:   return FM_BPSK;
      endcase
   endfunction

   // bits[1] is the first-transmitted bit; BPSK uses bits[0] only.
   function automatic iq_t psk_map(input logic [1:0] bits, input logic is_bpsk,
                                   input int amp_bpsk, input int amp_qpsk);
      iq_t r;
      if (is_bpsk) begin
         r.i = bits[0] ? -amp_bpsk : amp_bpsk;
         r.q = '0;
      end else begin
         r.i = bits[1] ? -amp_qpsk : amp_qpsk;
         r.q = bits[0] ? -amp_qpsk : amp_qpsk;
      end
      return r;
   endfunction

endpackage

// File: rtl/psk_frame_mapper_if.sv
// Byte stream into the PSK mapper: AXI-stream-style valid/ready/last.
interface psk_frame_mapper_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tlast;
   logic              tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/psk_sym_timer.sv
// Free-running symbol-rate divider; strobe marks the last cycle of each period.
module psk_sym_timer #(
   parameter int SYM_DIV = 16
) (
   input  logic clk_16M384,
   input  logic rst_16M384,
   output logic strobe
);
   localparam int CW = (SYM_DIV > 2) ? $clog2(SYM_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SYM_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk_16M384) begin
      if (rst_16M384)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign strobe = (cnt == LAST);
endmodule

// File: rtl/psk_frame_mapper.sv
// Serialises a framed byte stream MSB-first into BPSK/QPSK symbols and maps
// them to signed I/Q amplitudes at the symbol rate.
module psk_frame_mapper
   import psk_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int IQ_W      = 12,
   parameter int SYM_DIV   = 16,
   parameter int AMP_BPSK  = DEF_AMP_BPSK,
   parameter int AMP_QPSK  = DEF_AMP_QPSK,
   parameter int HDR_BYTES = DEF_HDR_BYTES
) (
   input  logic                   clk_16M384,
   input  logic                   rst_16M384,
   input  logic [3:0]             MODE_CTRL,
   psk_frame_mapper_if.slave      data,
   output logic signed [IQ_W-1:0] sym_I,
   output logic signed [IQ_W-1:0] sym_Q,
   output logic [1:0]             sym_bits,
   output logic                   sym_bpsk,
   output logic                   sym_vld,
   output logic                   sym_last,
   output logic                   underflow
);
   localparam int BW    = $clog2(DATA_W + 1);
   localparam int IDX_W = $clog2(HDR_BYTES + 2);
   localparam logic [BW-1:0]    FULL_BITS = BW'(DATA_W);
   localparam logic [IDX_W-1:0] HDR_IDX   = IDX_W'(HDR_BYTES);

   logic strobe;

   // hold register
   logic              hold_full, hold_last, hold_bpsk;
   logic [DATA_W-1:0] hold_data;
   // shift register
   logic [DATA_W-1:0] sh_data;
   logic [BW-1:0]     sh_bits;
   logic              sh_bpsk, sh_last;
   // frame tracking
   logic              frame_start, sym_idle;
   frame_mode_t       frame_mode;
   logic [IDX_W-1:0]  byte_idx;

   // combinational helpers
   logic              accept, acc_bpsk, sh_has, have_sym, src_bpsk, src_last, out_last;
   frame_mode_t       cur_mode;
   logic [IDX_W-1:0]  cur_idx, idx_nxt;
   logic [DATA_W-1:0] src_data;
   logic [BW-1:0]     src_bits, rem_bits;
   logic [1:0]        nxt_bits;
   iq_t               map;

   psk_sym_timer #(.SYM_DIV(SYM_DIV)) u_timer (
      .clk_16M384 (clk_16M384),
      .rst_16M384 (rst_16M384),
      .strobe     (strobe)
   );

   assign data.tready = ~hold_full;

   always_comb begin
      accept   = data.tvalid & ~hold_full;
      cur_mode = frame_start ? decode_mode(MODE_CTRL) : frame_mode;
      cur_idx  = frame_start ? '0 : byte_idx;
      idx_nxt  = (cur_idx < HDR_IDX) ? cur_idx + IDX_W'(1) : cur_idx;
      acc_bpsk = (cur_mode == FM_BPSK) || ((cur_mode == FM_MIX) && (cur_idx < HDR_IDX));

      // Shift register has priority; the hold byte is only tapped once it is empty.
      sh_has   = (sh_bits != '0);
      have_sym = strobe & (sh_has | hold_full);
      src_data = sh_has ? sh_data : hold_data;
      src_bits = sh_has ? sh_bits : FULL_BITS;
      src_bpsk = sh_has ? sh_bpsk : hold_bpsk;
      src_last = sh_has ? sh_last : hold_last;
      rem_bits = src_bits - (src_bpsk ? BW'(1) : BW'(2));
      out_last = src_last & (rem_bits == '0);
      nxt_bits = src_bpsk ? {1'b0, src_data[DATA_W-1]} : src_data[DATA_W-1 -: 2];
      map      = psk_map(nxt_bits, src_bpsk, AMP_BPSK, AMP_QPSK);
   end

   always_ff @(posedge clk_16M384) begin
      if (rst_16M384) begin
         hold_full   <= 1'b0;
         hold_last   <= 1'b0;
         hold_bpsk   <= 1'b0;
         hold_data   <= '0;
         sh_data     <= '0;
         sh_bits     <= '0;
         sh_bpsk     <= 1'b0;
         sh_last     <= 1'b0;
         frame_start <= 1'b1;
         frame_mode  <= FM_BPSK;
         byte_idx    <= '0;
         sym_idle    <= 1'b1;
         sym_I       <= '0;
         sym_Q       <= '0;
         sym_bits    <= '0;
         sym_bpsk    <= 1'b0;
         sym_vld     <= 1'b0;
         sym_last    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         sym_vld <= 1'b0;

         if (have_sym && !sh_has)
            hold_full <= 1'b0;
         if (accept) begin
            hold_full   <= 1'b1;
            hold_data   <= data.tdata;
            hold_last   <= data.tlast;
            hold_bpsk   <= acc_bpsk;
            frame_mode  <= cur_mode;
            frame_start <= data.tlast;
            byte_idx    <= data.tlast ? '0 : idx_nxt;
         end

         if (have_sym) begin
            sh_data  <= src_bpsk ? (src_data << 1) : (src_data << 2);
            sh_bits  <= rem_bits;
            sh_bpsk  <= src_bpsk;
            sh_last  <= src_last;
            sym_vld  <= 1'b1;
            sym_I    <= IQ_W'(map.i);
            sym_Q    <= IQ_W'(map.q);
            sym_bits <= nxt_bits;
            sym_bpsk <= src_bpsk;
            sym_last <= out_last;
            sym_idle <= out_last;
         end else if (strobe) begin
            // Empty slot: silence the outputs; it is an underflow only inside a frame.
            sym_I    <= '0;
            sym_Q    <= '0;
            sym_bits <= '0;
            sym_bpsk <= 1'b0;
            sym_last <= 1'b0;
            if (!sym_idle)
               underflow <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_psk_frame_mapper.sv
// Directed bench for psk_frame_mapper: BPSK, QPSK, MIX, backpressure, stall
// and mid-byte reset, with hand-computed symbol expectations.
module tb_psk_frame_mapper;
   import psk_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] mode_ctrl = MODE_BPSK;
   logic signed [11:0] sym_I, sym_Q;
   logic [1:0] sym_bits;
   logic sym_bpsk, sym_vld, sym_last, underflow;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int nready = 0;

   typedef struct {
      int i;
      int q;
      int bits;
      int bpsk;
      int last;
      int cyc;
   } sym_t;
   sym_t syms[$];

   psk_frame_mapper_if #(.DATA_W(8)) data_if ();

   psk_frame_mapper #(
      .DATA_W(8), .IQ_W(12), .SYM_DIV(16),
      .AMP_BPSK(2047), .AMP_QPSK(1447), .HDR_BYTES(2)
   ) dut (
      .clk_16M384 (clk),
      .rst_16M384 (rst),
      .MODE_CTRL  (mode_ctrl),
      .data       (data_if),
      .sym_I      (sym_I),
      .sym_Q      (sym_Q),
      .sym_bits   (sym_bits),
      .sym_bpsk   (sym_bpsk),
      .sym_vld    (sym_vld),
      .sym_last   (sym_last),
      .underflow  (underflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : monitor
      sym_t s;
      if (sym_vld === 1'b1) begin
         s.i = sym_I;
         s.q = sym_Q;
         s.bits = sym_bits;
         s.bpsk = sym_bpsk;
         s.last = sym_last;
         s.cyc = cyc;
         syms.push_back(s);
      end
      if (data_if.tready === 1'b0) nready <= nready + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [31:0] observed,
                      input logic signed [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, input logic [3:0] m);
      int n = 0;
      @(negedge clk);
      mode_ctrl = m;
      data_if.tdata = b;
      data_if.tvalid = 1'b1;
      data_if.tlast = last;
      while (data_if.tready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("tready_%02h", b), data_if.tready, 1);
      @(posedge clk);
   endtask

   task automatic stop_tx();
      @(negedge clk);
      data_if.tvalid = 1'b0;
      data_if.tlast = 1'b0;
   endtask

   task automatic wait_syms(input string tag, input int target, input int budget);
      int n = 0;
      while (syms.size() < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk(tag, syms.size(), target);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_vld"}, sym_vld, 0);
      chk({tag, "_I"}, sym_I, 0);
      chk({tag, "_Q"}, sym_Q, 0);
      chk({tag, "_bits"}, sym_bits, 0);
      chk({tag, "_bpsk"}, sym_bpsk, 0);
      chk({tag, "_last"}, sym_last, 0);
      chk({tag, "_underflow"}, underflow, 0);
      chk({tag, "_tready"}, data_if.tready, 1);
   endtask

   int base, rel, nr0;
   int exp_a5[8] = '{-2047, 2047, -2047, 2047, 2047, -2047, 2047, -2047};
   int exp_1b_i[4] = '{1447, 1447, -1447, -1447};
   int exp_1b_q[4] = '{1447, -1447, 1447, -1447};
   int exp_e4_i[4] = '{-1447, -1447, 1447, 1447};
   int exp_e4_q[4] = '{-1447, 1447, -1447, 1447};
   int exp_3c[8] = '{2047, 2047, -2047, -2047, -2047, -2047, 2047, 2047};
   logic [7:0] frame16[16];
   logic [7:0] bv;
   logic [1:0] pr;

   initial begin
      data_if.tdata = '0;
      data_if.tvalid = 1'b0;
      data_if.tlast = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rel = cyc;
      chk_reset_state("reset");

      // BPSK single byte 0xA5
      base = syms.size();
      send_byte(8'hA5, 1'b1, MODE_BPSK);
      stop_tx();
      wait_syms("t1_count", base + 8, 400);
      chk("t1_first_latency", syms[base].cyc - rel, 16);
      bv = 8'hA5;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t1_I[%0d]", k), syms[base+k].i, exp_a5[k]);
         chk($sformatf("t1_Q[%0d]", k), syms[base+k].q, 0);
         chk($sformatf("t1_bits[%0d]", k), syms[base+k].bits, int'(bv[7-k]));
         chk($sformatf("t1_bpsk[%0d]", k), syms[base+k].bpsk, 1);
         chk($sformatf("t1_last[%0d]", k), syms[base+k].last, (k == 7) ? 1 : 0);
         if (k > 0) chk($sformatf("t1_gap[%0d]", k), syms[base+k].cyc - syms[base+k-1].cyc, 16);
      end

      // QPSK single byte 0x1B
      base = syms.size();
      send_byte(8'h1B, 1'b1, MODE_QPSK);
      stop_tx();
      wait_syms("t2_count", base + 4, 400);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t2_I[%0d]", k), syms[base+k].i, exp_1b_i[k]);
         chk($sformatf("t2_Q[%0d]", k), syms[base+k].q, exp_1b_q[k]);
         chk($sformatf("t2_bits[%0d]", k), syms[base+k].bits, k);
         chk($sformatf("t2_bpsk[%0d]", k), syms[base+k].bpsk, 0);
         chk($sformatf("t2_last[%0d]", k), syms[base+k].last, (k == 3) ? 1 : 0);
      end

      // MIX frame: two BPSK header bytes then QPSK payload
      base = syms.size();
      send_byte(8'hFF, 1'b0, MODE_MIX);
      send_byte(8'h00, 1'b0, MODE_MIX);
      send_byte(8'hE4, 1'b0, MODE_MIX);
      send_byte(8'h1B, 1'b1, MODE_MIX);
      stop_tx();
      wait_syms("t3_count", base + 24, 800);
      repeat (40) @(negedge clk);
      chk("t3_exact_count", syms.size() - base, 24);
      chk("t3_underflow", underflow, 0);
      for (int k = 0; k < 24; k++) begin
         chk($sformatf("t3_bpsk[%0d]", k), syms[base+k].bpsk, (k < 16) ? 1 : 0);
         chk($sformatf("t3_last[%0d]", k), syms[base+k].last, (k == 23) ? 1 : 0);
         if (k > 0) chk($sformatf("t3_gap[%0d]", k), syms[base+k].cyc - syms[base+k-1].cyc, 16);
         if (k < 8) chk($sformatf("t3_I[%0d]", k), syms[base+k].i, -2047);
         else if (k < 16) chk($sformatf("t3_I[%0d]", k), syms[base+k].i, 2047);
         else if (k < 20) begin
            chk($sformatf("t3_I[%0d]", k), syms[base+k].i, exp_e4_i[k-16]);
            chk($sformatf("t3_Q[%0d]", k), syms[base+k].q, exp_e4_q[k-16]);
         end else begin
            chk($sformatf("t3_I[%0d]", k), syms[base+k].i, exp_1b_i[k-20]);
            chk($sformatf("t3_Q[%0d]", k), syms[base+k].q, exp_1b_q[k-20]);
         end
         if (k < 16) chk($sformatf("t3_Q[%0d]", k), syms[base+k].q, 0);
      end

      // Continuous QPSK 16-byte frame; MODE_CTRL flips to BPSK halfway through
      for (int i = 0; i < 16; i++) frame16[i] = 8'(i * 37 + 29);
      base = syms.size();
      nr0 = nready;
      for (int i = 0; i < 16; i++)
         send_byte(frame16[i], (i == 15), (i < 8) ? MODE_QPSK : MODE_BPSK);
      stop_tx();
      wait_syms("t4_count", base + 64, 2000);
      chk("t4_backpressure", (nready - nr0) > 0, 1);
      chk("t4_span", syms[base+63].cyc - syms[base].cyc, 63 * 16);
      for (int k = 0; k < 64; k++) begin
         bv = frame16[k/4];
         pr = bv[7 - 2*(k%4) -: 2];
         chk($sformatf("t4_I[%0d]", k), syms[base+k].i, pr[1] ? -1447 : 1447);
         chk($sformatf("t4_Q[%0d]", k), syms[base+k].q, pr[0] ? -1447 : 1447);
         chk($sformatf("t4_bpsk[%0d]", k), syms[base+k].bpsk, 0);
      end
      chk("t4_underflow", underflow, 0);

      // Next frame picks up the BPSK setting
      base = syms.size();
      send_byte(8'h3C, 1'b1, MODE_BPSK);
      stop_tx();
      wait_syms("t4b_count", base + 8, 400);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("t4b_I[%0d]", k), syms[base+k].i, exp_3c[k]);
         chk($sformatf("t4b_bpsk[%0d]", k), syms[base+k].bpsk, 1);
      end

      // Stall after byte 1 of 3
      base = syms.size();
      send_byte(8'hC3, 1'b0, MODE_BPSK);
      stop_tx();
      wait_syms("t5_first_byte", base + 8, 400);
      repeat (40) @(negedge clk);
      chk("t5_no_syms_in_stall", syms.size() - base, 8);
      chk("t5_vld_empty", sym_vld, 0);
      chk("t5_I_empty", sym_I, 0);
      chk("t5_Q_empty", sym_Q, 0);
      chk("t5_underflow_set", underflow, 1);
      send_byte(8'h55, 1'b0, MODE_BPSK);
      send_byte(8'hAA, 1'b1, MODE_BPSK);
      stop_tx();
      wait_syms("t5_count", base + 24, 800);
      chk("t5_stall_gap", (syms[base+8].cyc - syms[base+7].cyc) > 16, 1);
      chk("t5_I[8]", syms[base+8].i, 2047);
      chk("t5_I[16]", syms[base+16].i, -2047);
      chk("t5_last[23]", syms[base+23].last, 1);
      repeat (40) @(negedge clk);
      chk("t5_underflow_sticky", underflow, 1);

      // Reset mid-byte, then a new frame with an invalid mode code (decodes as BPSK)
      base = syms.size();
      send_byte(8'h0F, 1'b0, MODE_BPSK);
      stop_tx();
      wait_syms("t6_partial", base + 3, 400);
      chk("t6_underflow_before", underflow, 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      rel = cyc;
      chk_reset_state("t6_after_reset");
      base = syms.size();
      send_byte(8'h80, 1'b1, 4'b0000);
      stop_tx();
      wait_syms("t6_count", base + 8, 400);
      repeat (40) @(negedge clk);
      chk("t6_exact_count", syms.size() - base, 8);
      chk("t6_first_latency", syms[base].cyc - rel, 16);
      chk("t6_I[0]", syms[base].i, -2047);
      chk("t6_I[1]", syms[base+1].i, 2047);
      chk("t6_I[7]", syms[base+7].i, 2047);
      chk("t6_bpsk[0]", syms[base].bpsk, 1);
      chk("t6_last[6]", syms[base+6].last, 0);
      chk("t6_last[7]", syms[base+7].last, 1);
      chk("t6_underflow", underflow, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/psk_frame_mapper.md
Name: psk_frame_mapper

Overview:
- Parametrised successor to the fixed-mode Tx bit path.
- Accepts a byte stream with AXI-stream-style valid/ready/last handshake and serialises each byte MSB-first into symbols.
- Maps symbols to signed I/Q baseband amplitudes at a programmable symbol rate, in BPSK, QPSK, or MIX mode (BPSK header, then QPSK payload, per frame).
- Sits between the frame builder and the upsampling/NCO mixer ahead of the DAC.

Parameters:
- DATA_W, 8, input byte width; must be even.
- IQ_W, 12, signed I/Q output width.
- SYM_DIV, 16, clk_16M384 cycles per symbol (16 gives 1.024 Msym/s); must be ≥2.
- AMP_BPSK, 2047, BPSK I magnitude.
- AMP_QPSK, 1447, QPSK I and Q magnitude (≈AMP_BPSK/√2).
- HDR_BYTES, 2, number of leading BPSK bytes per frame in MIX mode.

Ports:
- clk_16M384, in, 1, system clock.
- rst_16M384, in, 1, synchronous active-high reset.
- MODE_CTRL, in, 4, one-hot mode: 0001 BPSK, 0010 QPSK, 0100 MIX; any other value is decoded as BPSK.
- data_tdata, in, DATA_W, payload byte.
- data_tvalid, in, 1, byte valid.
- data_tlast, in, 1, last byte of frame.
- data_tready, out, 1, byte accepted when tvalid&tready.
- sym_I, out, IQ_W, signed I amplitude.
- sym_Q, out, IQ_W, signed Q amplitude.
- sym_bits, out, 2, raw symbol bits; BPSK uses {1'b0,b}.
- sym_bpsk, out, 1, current symbol is BPSK.
- sym_vld, out, 1, one-cycle strobe per data symbol.
- sym_last, out, 1, final symbol of frame; qualified by sym_vld.
- underflow, out, 1, sticky: a symbol slot went empty mid-frame.

Behaviour:
- Reset (synchronous, active-high) clears everything:
  - All outputs 0 except data_tready=1.
  - Divider cnt=0, hold and shift registers empty, byte index 0, frame-start flag set.
- Divider: cnt counts 0..SYM_DIV-1 and wraps. The strobe cycle is cnt==SYM_DIV-1. Free-running, including when idle.
- Buffering:
  - One hold register (byte, tlast, per-byte mode) plus one shift register (bits left, mode, last-flag).
  - data_tready = ~hold_full. Acceptance sets hold_full on the next edge.
- Mode latch:
  - MODE_CTRL is sampled only on the first accepted byte of a frame (after reset or after a byte with tlast). It is held for the whole frame.
  - A mid-frame MODE_CTRL change takes effect from the next frame.
- Per-byte mode:
  - BPSK frame: every byte is BPSK.
  - QPSK frame: every byte is QPSK.
  - MIX frame: byte index < HDR_BYTES is BPSK, otherwise QPSK. The index saturates at HDR_BYTES.
  - A frame shorter than HDR_BYTES is entirely BPSK.
- On the strobe cycle, the symbol source is chosen in this order:
  - Shift register has bits: consume 1 bit (BPSK) or 2 bits (QPSK) from its MSB end.
  - Shift register empty and hold full: take the symbol from the hold byte's MSBs, move the remainder into the shift register, and clear hold_full. A byte accepted on that same cycle goes into hold.
  - Both empty: no symbol. sym_vld stays 0 and sym_I/sym_Q are driven to 0. If the previous symbol was not a frame-last symbol, set underflow.
- Output latency: registered. sym_vld pulses on the cycle after the strobe cycle. sym_I/sym_Q/sym_bits/sym_bpsk/sym_last hold their values until the next strobe.
- Mapping (b1 is the first-transmitted bit):
  - BPSK: I = b ? −AMP_BPSK : +AMP_BPSK; Q = 0.
  - QPSK (Gray): I = b1 ? −AMP_QPSK : +AMP_QPSK; Q = b0 ? −AMP_QPSK : +AMP_QPSK.
  - Constants are sign-extended or truncated to IQ_W.
- sym_last: asserted on the final symbol of a byte tagged tlast. That is symbol 8 in BPSK and symbol 4 in QPSK for DATA_W=8.
- Throughput: one byte lasts 8 or 4 symbol periods. Sustained tvalid with backpressure must produce gapless symbols; no underflow when the source is ready within SYM_DIV−1 cycles of tready rising.
- Reset mid-frame: the partial byte and held byte are discarded, underflow is cleared, and the next accepted byte starts a new frame.

Decomposition:
- Shared package psk_pkg holds:
  - MODE_BPSK/MODE_QPSK/MODE_MIX localparams.
  - Default amplitude constants.
  - A function mapping {bits, is_bpsk} to {I, Q}, for reuse by the Rx reference model.
- One sub-module is natural: psk_sym_timer (divider plus strobe output), also reusable by the Rx symbol sync.

Test Plan:
- Reset then BPSK, single byte 0xA5 with tlast:
  - sym_vld ×8 at 16-cycle spacing, first pulse 1 cycle after the first strobe.
  - sym_I sequence −2047,+2047,−2047,+2047,+2047,−2047,+2047,−2047; sym_Q=0; sym_last only on the 8th.
- QPSK, byte 0x1B (bits 00,01,10,11) with tlast:
  - I/Q = (+1447,+1447), (+1447,−1447), (−1447,+1447), (−1447,−1447).
  - sym_last on the 4th.
- MIX, HDR_BYTES=2, frame of 4 bytes 0xFF,0x00,0xE4,0x1B:
  - 16 BPSK symbols then 8 QPSK symbols; sym_bpsk drops after symbol 16.
  - Exactly 24 sym_vld pulses, underflow=0.
- Continuous tvalid in QPSK, 16-byte frame:
  - No sym_vld gaps (64 pulses, 1024 cycles); data_tready deasserts while hold is full.
  - MODE_CTRL toggled mid-frame has no effect until the next frame.
- Stall mid-frame (tvalid=0 for 40 cycles after byte 1 of 3):
  - Missing slots give sym_vld=0 and I/Q=0.
  - underflow=1 and stays sticky until reset.
- Assert rst_16M384 for 1 cycle mid-byte:
  - All outputs return to reset values the next cycle; data_tready=1.
  - Next byte 0x80 (BPSK) yields a first symbol of −2047 as a new frame.
